// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
// The state encoding is one-hot; DW defaults to the merging stage's output width.
package tdc_meas_ctrl_pkg;

  localparam int DIG_OUT            = 32;
  localparam int DEF_DW             = DIG_OUT;
  localparam int DEF_RST_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;
  localparam int DEF_CNT_W          = 16;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_CLEAR  = 5'b00010,
    ST_ARMED  = 5'b00100,
    ST_SETTLE = 5'b01000,
    ST_HOLD   = 5'b10000
  } meas_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tdc_meas_ctrl_meas_timer.sv
// Loadable down-counter that CLEAR and ARMED share.
// o_expire is high while the timer is enabled and the count has reached zero.
module meas_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_expire
);

  logic [TW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments, so every flop sees the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Sequences one TDC measurement: clear, arm, wait for done or no-hit timeout,
// capture the merged word, then hold it on a valid/ready port. Every output is a flop.
module tdc_meas_ctrl
  import tdc_meas_ctrl_pkg::*;
#(
  parameter int DW             = DEF_DW,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start_req,
  input  logic             i_cont_mode,
  input  logic             i_abort,
  input  logic             i_tdc_done,
  input  logic [DW-1:0]    i_tdc_out,
  output logic             o_tdc_rst,
  output logic             o_tdc_arm,
  output logic [DW-1:0]    o_res_data,
  output logic             o_res_timeout,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_meas_count
);

  localparam int TW = $clog2(max_int(RST_CYCLES, TIMEOUT_CYCLES));

  meas_state_e      r_state;
  logic             r_tdc_rst;
  logic             r_tdc_arm;
  logic [DW-1:0]    r_res_data;
  logic             r_res_timeout;
  logic             r_res_valid;
  logic             r_busy;
  logic             r_pending;
  logic [CNT_W-1:0] r_meas_count;

  logic             w_in_clear;
  logic             w_in_armed;
  logic             w_tmr_load;
  logic [TW-1:0]    w_tmr_val;
  logic             w_expire;

  assign w_in_clear = (r_state == ST_CLEAR);
  assign w_in_armed = (r_state == ST_ARMED);

  // Outside CLEAR/ARMED the timer is preloaded with the CLEAR length; the last CLEAR
  // cycle reloads it with the ARMED budget so both windows start counting on entry.
  assign w_tmr_load = !(w_in_clear || w_in_armed) || (w_in_clear && w_expire);
  assign w_tmr_val  = w_in_clear ? TW'(TIMEOUT_CYCLES - 1) : TW'(RST_CYCLES - 1);

  meas_timer #(
    .TW(TW)
  ) u_meas_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_in_clear || w_in_armed),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tdc_rst     <= 1'b1;
      r_tdc_arm     <= 1'b0;
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_pending     <= 1'b0;
      r_meas_count  <= '0;
    end else if (i_abort) begin
      r_state     <= ST_IDLE;
      r_tdc_rst   <= 1'b1;
      r_tdc_arm   <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      // One-deep request queue; the handshake in HOLD consumes it.
      if ((r_state != ST_IDLE) && i_start_req) begin
        r_pending <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (i_start_req || i_cont_mode) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (w_expire) begin
            r_state   <= ST_ARMED;
            r_tdc_rst <= 1'b0;
            r_tdc_arm <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (i_tdc_done) begin
            r_state   <= ST_SETTLE;
            r_tdc_arm <= 1'b0;
          end else if (w_expire) begin
            r_state       <= ST_HOLD;
            r_tdc_arm     <= 1'b0;
            r_tdc_rst     <= 1'b1;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b1;
            r_res_data    <= '0;
          end
        end
        ST_SETTLE: begin
          // The merging stage updates its output on the done edge, so it is stable only now.
          r_state       <= ST_HOLD;
          r_tdc_rst     <= 1'b1;
          r_res_valid   <= 1'b1;
          r_res_timeout <= 1'b0;
          r_res_data    <= i_tdc_out;
        end
        ST_HOLD: begin
          if (i_res_ready) begin
            r_res_valid  <= 1'b0;
            r_pending    <= 1'b0;
            r_meas_count <= r_meas_count + CNT_W'(1);
            if (i_cont_mode || r_pending) begin
              r_state <= ST_CLEAR;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_tdc_rst   <= 1'b1;
          r_tdc_arm   <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_tdc_rst     = r_tdc_rst;
  assign o_tdc_arm     = r_tdc_arm;
  assign o_res_data    = r_res_data;
  assign o_res_timeout = r_res_timeout;
  assign o_res_valid   = r_res_valid;
  assign o_busy        = r_busy;
  assign o_meas_count  = r_meas_count;

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the TDC capture path (delay line, decoders, coarse counter, merging stage).
- Sequence per measurement: hold the TDC in reset, release and arm it, wait for the merging stage's one-cycle done pulse, capture the merged word, then present it downstream on a valid/ready interface.
- Provides single-shot and continuous modes, a no-hit timeout, and abort.
- Sits between the TDC core and the readout/UART packetiser.

Parameters:
DW, 32, width of merged TDC word (must equal DIG_OUT of the merging stage)
RST_CYCLES, 4, cycles tdc_rst is held high in CLEAR (>=2)
TIMEOUT_CYCLES, 256, ARMED cycles allowed before declaring no-hit (>=2)
CNT_W, 16, width of meas_count

Ports:
clk  in  1  system clock (same clock as merging stage)
rst  in  1  reset, asynchronous, active-high
start_req  in  1  request one measurement (level sampled each cycle)
cont_mode  in  1  1 = re-arm automatically after each accepted result
abort  in  1  synchronous abort to IDLE
tdc_done  in  1  one-cycle done pulse from merging stage
tdc_out  in  DW  merged word {Coarse, Start, Stop} from merging stage
tdc_rst  out  1  reset to TDC core (drives irst)
tdc_arm  out  1  hit-gating enable to TDC front end
res_data  out  DW  captured result
res_timeout  out  1  result is a timeout (res_data = 0)
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
busy  out  1  state != IDLE
meas_count  out  CNT_W  accepted-result counter, wraps at 2^CNT_W

Behaviour:
- Reset values: state IDLE, tdc_rst=1, tdc_arm=0, res_valid=0, res_timeout=0, res_data=0, busy=0, meas_count=0, pending=0.
- All outputs are flop outputs. No combinational decode may drive tdc_rst or tdc_arm, so tdc_rst is glitch-free.
- IDLE:
  - tdc_rst=1.
  - start_req=1 or cont_mode=1 -> CLEAR.
- CLEAR:
  - tdc_rst=1; cycle counter from 0.
  - After exactly RST_CYCLES cycles in CLEAR -> ARMED.
- ARMED:
  - tdc_rst=0, tdc_arm=1; timer starts at 0 on entry.
  - tdc_done=1 -> SETTLE.
  - Else timer==TIMEOUT_CYCLES-1 -> HOLD with res_timeout=1, res_data=0.
  - tdc_done and timeout in the same cycle: done wins.
- SETTLE (1 cycle):
  - tdc_arm=0, tdc_rst=0. The merging stage updates out on the done edge, so tdc_out is sampled here.
  - res_data<=tdc_out, res_timeout<=0 -> HOLD.
- HOLD:
  - res_valid=1, tdc_rst=1, tdc_arm=0; res_data and res_timeout stable.
  - On res_valid & res_ready: meas_count+1; res_valid drops next cycle.
  - Next state: CLEAR if cont_mode or pending, else IDLE; pending cleared.
- Latency:
  - start_req sampled high at cycle 0 -> tdc_rst high cycles 1..RST_CYCLES, ARMED from cycle RST_CYCLES+1.
  - tdc_done at cycle k -> res_valid=1 at k+2.
- start_req while busy sets pending (one deep); further requests are dropped.
- abort (any state, priority over everything except rst):
  - Next state IDLE, res_valid=0, pending=0, tdc_rst=1.
  - meas_count unchanged.
- tdc_done outside ARMED is ignored.
- rst mid-operation: immediate return to reset values; no partial result is emitted.

Decomposition:
- Shared package/defines:
  - state encoding constants: IDLE, CLEAR, ARMED, SETTLE, HOLD, one-hot 5 bits
  - DW tied to DIG_OUT
  - default RST_CYCLES and TIMEOUT_CYCLES
- One sub-module, meas_timer:
  - loadable down-counter shared by CLEAR and ARMED
  - width clog2(max(RST_CYCLES,TIMEOUT_CYCLES))
  - outputs expire pulse

Test Plan:
- Single shot: start_req pulse at c0, tdc_done at c9, tdc_out=32'h00A5_1234 at c10, res_ready=1 -> tdc_rst high c1..c4, tdc_arm c5..c9, res_valid at c11 with 32'h00A5_1234, res_timeout=0, meas_count=1, back to IDLE.
- Timeout: start_req, no tdc_done -> HOLD after 256 ARMED cycles, res_timeout=1, res_data=0, tdc_arm drops exactly when timeout fires.
- Backpressure/continuous: cont_mode=1, res_ready=0 for 20 cycles -> res_data held constant, no new CLEAR. res_ready=1 -> one transfer, meas_count+1, CLEAR next cycle.
- Pending: start_req twice during ARMED -> exactly two results total, second measurement starts CLEAR the cycle after the first handshake.
- Collision: tdc_done in the same cycle timer expires -> captured data result, res_timeout=0.
- Abort/reset: abort in ARMED -> IDLE next cycle, no res_valid, tdc_rst=1. rst asserted during HOLD -> res_valid=0 immediately, meas_count=0.
